// File: rtl/number_entry.sv
// number_entry: keypad digit collection into a 4-place BCD entry register,
// followed by a multi-cycle BCD-to-binary conversion (MSB nibble first,
// acc = acc*10 + nibble each cycle) producing a 14-bit operand.
module number_entry #(
    parameter int CONV_STEPS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        digit_valid,
    input  logic [3:0]  digit_in,
    input  logic        backspace,
    input  logic        clear,
    input  logic        convert,
    output logic [15:0] entry_bcd,
    output logic [2:0]  digit_count,
    output logic [13:0] number_o,
    output logic        number_valid,
    output logic        busy,
    output logic        error
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_CONV = 1'b1;
    localparam logic [1:0] LAST_STEP = 2'(CONV_STEPS - 1);

    logic        state;
    logic [1:0]  step;
    logic [13:0] acc;
    logic [3:0]  nib;
    logic [13:0] acc_next;
    logic        digit_ok;

    // a digit is only taken if it is legal BCD and there is room for it
    assign digit_ok = (digit_in <= 4'd9) && (digit_count < 3'd4);

    // pick the nibble for this step (thousands first) and form acc*10 + nibble
    always_comb begin
        nib = 4'h0;
        case (step)
            2'd0: nib = entry_bcd[15:12];
            2'd1: nib = entry_bcd[11:8];
            2'd2: nib = entry_bcd[7:4];
            default: nib = entry_bcd[3:0];
        endcase
        // max intermediate is 9999, fits in 14 bits without wrap
        acc_next = (acc << 3) + (acc << 1) + {10'd0, nib};
    end

    // edit handling in IDLE, one conversion step per cycle in CONV
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            step         <= 2'd0;
            acc          <= 14'd0;
            entry_bcd    <= 16'h0000;
            digit_count  <= 3'd0;
            number_o     <= 14'd0;
            number_valid <= 1'b0;
            busy         <= 1'b0;
            error        <= 1'b0;
        end else begin
            error <= 1'b0;
            if (state == ST_IDLE) begin
                if (clear) begin
                    entry_bcd    <= 16'h0000;
                    digit_count  <= 3'd0;
                    number_valid <= 1'b0;
                end else if (backspace) begin
                    // backspace on an empty entry is a silent no-op
                    if (digit_count != 3'd0) begin
                        entry_bcd    <= {4'h0, entry_bcd[15:4]};
                        digit_count  <= digit_count - 3'd1;
                        number_valid <= 1'b0;
                    end
                end else if (digit_valid) begin
                    if (digit_ok) begin
                        entry_bcd    <= {entry_bcd[11:0], digit_in};
                        digit_count  <= digit_count + 3'd1;
                        number_valid <= 1'b0;
                    end else begin
                        error <= 1'b1;
                    end
                end else if (convert) begin
                    state <= ST_CONV;
                    step  <= 2'd0;
                    acc   <= 14'd0;
                    busy  <= 1'b1;
                end
            end else begin
                if (clear) begin
                    // abort: entry emptied, last result kept but no longer valid
                    state        <= ST_IDLE;
                    step         <= 2'd0;
                    acc          <= 14'd0;
                    busy         <= 1'b0;
                    entry_bcd    <= 16'h0000;
                    digit_count  <= 3'd0;
                    number_valid <= 1'b0;
                end else begin
                    if (digit_valid || backspace || convert)
                        error <= 1'b1;
                    acc  <= acc_next;
                    step <= step + 2'd1;
                    if (step == LAST_STEP) begin
                        number_o     <= acc_next;
                        number_valid <= 1'b1;
                        busy         <= 1'b0;
                        state        <= ST_IDLE;
                    end
                end
            end
        end
    end

endmodule

// File: doc/number_entry.md
# number_entry

Decimal entry block for the calculator datapath: collects up to four keypad digit strobes into a BCD entry register and converts it sequentially into a 14-bit binary operand. It is the inverse of the display path, which splits a 14-bit binary value into four decimal places. It sits between the keypad/button front end and the calculator ALU. The BCD register is also exported so the entry can be echoed on the seven-segment display while typing.

## Interface
- `CONV_STEPS`, default 4: number of decimal places (fixed at 4). Conversion takes exactly this many cycles.
- `clk` input 1: system clock. All state changes on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `digit_valid` input 1: one-cycle strobe; `digit_in` is valid.
- `digit_in` input 4: BCD digit to append. Legal values 0-9.
- `backspace` input 1: one-cycle strobe; remove the least significant entered digit.
- `clear` input 1: one-cycle strobe; empty the entry and abort any conversion.
- `convert` input 1: one-cycle strobe; start BCD-to-binary conversion.
- `entry_bcd` output 16: four BCD nibbles. [15:12] is thousands and [3:0] is units. Unused places are zero-padded.
- `digit_count` output 3: number of entered digits, 0-4.
- `number_o` output 14: last converted binary value.
- `number_valid` output 1: high while `number_o` matches the current entry.
- `busy` output 1: conversion in progress.
- `error` output 1: one-cycle pulse when an input is rejected.

## Operation
- **States.** The block has two states, IDLE and CONV.
- **Edit priority in IDLE.** `clear` beats `backspace`, which beats `digit_valid`. Only one action is taken per cycle.
- **Digit, accepted.** Applies when `digit_in` ≤ 9 and `digit_count` < 4.
  - `entry_bcd` becomes `{entry_bcd[11:0], digit_in}`.
  - `digit_count` increments by 1.
  - `number_valid` goes to 0.
- **Digit, rejected.** Applies when `digit_in` > 9 or `digit_count` == 4.
  - Entry is unchanged.
  - `error` pulses for 1 cycle.
- **Backspace.**
  - When `digit_count` > 0: `entry_bcd` becomes `{4'h0, entry_bcd[15:4]}`, `digit_count` decrements by 1, and `number_valid` goes to 0.
  - When `digit_count` == 0: no-op, no error.
- **Clear.** `entry_bcd` = 0, `digit_count` = 0, `number_valid` = 0. `number_o` is retained.
- **Convert in IDLE.** Only accepted when no edit strobe is active in the same cycle; an edit strobe wins and `convert` is dropped silently.
  - On acceptance: state goes to CONV, step = 0, accumulator = 0, `busy` = 1.
  - An empty entry (`digit_count` = 0) converts to 0.
- **CONV, one step per cycle** (steps 0..3, most significant nibble first):
  - acc ← acc·10 + `entry_bcd[15-4·step -: 4]`.
  - ×10 is implemented as (acc<<3)+(acc<<1) at 14 bits. Intermediate values never exceed 9999, so no overflow occurs.
- **Step 3 completion.**
  - `number_o` ← final value.
  - `number_valid` ← 1.
  - `busy` ← 0.
  - State returns to IDLE.
- **Inputs during CONV.**
  - `digit_valid`, `backspace` and `convert` are ignored and `error` pulses for 1 cycle.
  - `clear` is honoured. It aborts to IDLE, performs the clear action, leaves `number_o` unchanged and sets `busy` to 0.
- **Reset.** Asserting `reset` at any time forces:
  - `entry_bcd` = 0, `digit_count` = 0, `number_o` = 0;
  - `number_valid` = 0, `busy` = 0, `error` = 0;
  - state = IDLE and the accumulator cleared.

## Timing
- All outputs are registered. Nothing is combinational from inputs to outputs.
- **Edit latency.** An edit strobe sampled at edge k is visible on `entry_bcd`, `digit_count` and `number_valid` after edge k. The matching `error` pulse is high for the cycle after edge k only.
- **Conversion latency.** For `convert` sampled at edge k:
  - `busy` is high after edges k through k+3.
  - Steps execute at edges k+1 … k+4.
  - `number_o` and `number_valid` update, and `busy` falls, at edge k+4.
  - Total: 4 busy cycles; a new `convert` can be accepted at edge k+5.
- **Back-to-back strobes.** Strobes on consecutive cycles are each processed; no idle cycle is required between edits.
- **Held strobes.** A strobe held high for n cycles acts n times. Strobes are not edge-detected here; the front end is responsible for debouncing and pulse generation.

## Test plan
- **Full entry and conversion.** Reset, enter 1,2,3,4, then pulse `convert`.
  - `entry_bcd` = 0x1234 and `digit_count` = 4.
  - `busy` is high for exactly 4 cycles.
  - Then `number_o` = 1234 (0x4D2) and `number_valid` = 1.
- **Overflow and maximum value.** Enter 9,9,9,9,9.
  - The fifth digit pulses `error` and the entry stays 0x9999.
  - Converting gives `number_o` = 9999 (0x270F).
- **Illegal digit.** Apply `digit_in` = 0xA with `digit_valid`.
  - `error` pulses for 1 cycle.
  - `entry_bcd` and `digit_count` are unchanged.
- **Backspace.** Enter 1,2, then backspace → `entry_bcd` = 0x0001 and `digit_count` = 1. Convert → `number_o` = 1.
  - Three more backspaces → `digit_count` stays 0 with no `error`.
  - Convert → `number_o` = 0.
- **Clear mid-conversion.** Convert 1234, then enter 5 and convert again; pulse `clear` at the second busy cycle.
  - `busy` = 0 and `digit_count` = 0 after that edge.
  - `number_valid` = 0 and `number_o` stays 1234.
  - A `digit_valid` during busy pulses `error` and is ignored.
- **Reset mid-conversion.** Assert `reset` asynchronously between edges during CONV.
  - All outputs go to 0 immediately, without waiting for a clock edge.
  - After release, entering 7 and converting gives 7.
